// File: rtl/mem_bus_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single shared memory port: buffers one request per side,
// issues one transaction at a time and routes the response to its owner. Define ARB_RR_EN for round-robin ties.
module mem_bus_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,

    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        grant_lsu,
    output logic        proto_err
);

    // Handshake: every *_reqValid is a one-cycle pulse with its fields valid in that cycle; there is
    // no ready. The memory answers each mem_reqValid with exactly one mem_respValid, no earlier than
    // the cycle after the request, and the owner's respValid is that same cycle.

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    arb_state_t state;
    arb_state_t state_next;

    logic        ifu_pend;
    logic [31:0] ifu_addr_q;

    logic        lsu_pend;
    logic [31:0] lsu_addr_q;
    logic [31:0] lsu_wdata_q;
    logic [1:0]  lsu_size_q;
    logic        lsu_wen_q;
    logic [3:0]  lsu_wmask_q;

    logic        owner_lsu;
    logic        mem_req_q;

    logic        ifu_eff;
    logic        lsu_eff;
    logic [31:0] ifu_eff_addr;
    logic [31:0] lsu_eff_addr;
    logic [31:0] lsu_eff_wdata;
    logic [1:0]  lsu_eff_size;
    logic        lsu_eff_wen;
    logic [3:0]  lsu_eff_wmask;

    logic        take_ifu;
    logic        take_lsu;
    logic        ifu_drop;
    logic        lsu_drop;
    logic        resp_hit;
    logic        tie_lsu;

    // A buffered request takes precedence over the live inputs for its fields.
    assign ifu_eff       = ifu_pend | ifu_reqValid;
    assign lsu_eff       = lsu_pend | lsu_reqValid;
    assign ifu_eff_addr  = ifu_pend ? ifu_addr_q  : ifu_addr;
    assign lsu_eff_addr  = lsu_pend ? lsu_addr_q  : lsu_addr;
    assign lsu_eff_wdata = lsu_pend ? lsu_wdata_q : lsu_wdata;
    assign lsu_eff_size  = lsu_pend ? lsu_size_q  : lsu_size;
    assign lsu_eff_wen   = lsu_pend ? lsu_wen_q   : lsu_wen;
    assign lsu_eff_wmask = lsu_pend ? lsu_wmask_q : lsu_wmask;

    assign busy     = (state != ARB_IDLE);
    assign resp_hit = (state == ARB_WAIT) && mem_respValid;

    // A pulse is illegal while that side already has a buffered or in-flight transaction.
    assign ifu_drop = ifu_reqValid && (ifu_pend || (busy && !owner_lsu));
    assign lsu_drop = lsu_reqValid && (lsu_pend || (busy &&  owner_lsu));

`ifdef ARB_RR_EN
    logic last_grant_lsu;

    assign tie_lsu = !last_grant_lsu;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_lsu <= 1'b0;
        end else if (take_lsu) begin
            last_grant_lsu <= 1'b1;
        end else if (take_ifu) begin
            last_grant_lsu <= 1'b0;
        end
    end
`else
    assign tie_lsu = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_ifu   = 1'b0;
        take_lsu   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (lsu_eff && (!ifu_eff || tie_lsu)) begin
                    take_lsu   = 1'b1;
                    state_next = ARB_REQ;
                end else if (ifu_eff) begin
                    take_ifu   = 1'b1;
                    state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                // Only the non-owner can be waiting here, so no tie-break is needed.
                if (mem_respValid) begin
                    if (owner_lsu && ifu_eff) begin
                        take_ifu   = 1'b1;
                        state_next = ARB_REQ;
                    end else if (!owner_lsu && lsu_eff) begin
                        take_lsu   = 1'b1;
                        state_next = ARB_REQ;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifu_pend   <= 1'b0;
            ifu_addr_q <= 32'h0;
        end else if (take_ifu) begin
            ifu_pend <= 1'b0;
        end else if (ifu_reqValid && !ifu_drop) begin
            ifu_pend   <= 1'b1;
            ifu_addr_q <= ifu_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lsu_pend    <= 1'b0;
            lsu_addr_q  <= 32'h0;
            lsu_wdata_q <= 32'h0;
            lsu_size_q  <= 2'b00;
            lsu_wen_q   <= 1'b0;
            lsu_wmask_q <= 4'b0000;
        end else if (take_lsu) begin
            lsu_pend <= 1'b0;
        end else if (lsu_reqValid && !lsu_drop) begin
            lsu_pend    <= 1'b1;
            lsu_addr_q  <= lsu_addr;
            lsu_wdata_q <= lsu_wdata;
            lsu_size_q  <= lsu_size;
            lsu_wen_q   <= lsu_wen;
            lsu_wmask_q <= lsu_wmask;
        end
    end

    // Request fields are loaded on a grant and held until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req_q <= 1'b0;
            owner_lsu <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_size  <= 2'b00;
            mem_wen   <= 1'b0;
            mem_wmask <= 4'b0000;
        end else begin
            mem_req_q <= take_lsu | take_ifu;
            if (take_lsu) begin
                owner_lsu <= 1'b1;
                mem_addr  <= lsu_eff_addr;
                mem_wdata <= lsu_eff_wdata;
                mem_size  <= lsu_eff_size;
                mem_wen   <= lsu_eff_wen;
                mem_wmask <= lsu_eff_wmask;
            end else if (take_ifu) begin
                owner_lsu <= 1'b0;
                mem_addr  <= ifu_eff_addr;
                mem_wdata <= 32'h0;
                mem_size  <= 2'b10;
                mem_wen   <= 1'b0;
                mem_wmask <= 4'b0000;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (ifu_drop || lsu_drop) begin
            proto_err <= 1'b1;
        end
    end

    assign mem_reqValid  = mem_req_q;
    assign grant_lsu     = owner_lsu;
    assign ifu_respValid = resp_hit && !owner_lsu;
    assign lsu_respValid = resp_hit &&  owner_lsu;
    assign ifu_rdata     = mem_rdata;
    assign lsu_rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 time unit after a rising edge, outputs are
// checked at the falling edge. Expected values are hand-computed; ARB_RR_EN selects the tie order.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        grant_lsu;
    logic        proto_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ifu_txn_cnt = 0;
    int ifu_txn_base;
    logic exp_first [3];

    mem_bus_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_size      (lsu_size),
        .lsu_wen       (lsu_wen),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_size      (mem_size),
        .mem_wen       (mem_wen),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .grant_lsu     (grant_lsu),
        .proto_err     (proto_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish before 200000");
        $fatal(1);
    end

    always @(negedge clock) begin
        if (mem_reqValid && !grant_lsu) ifu_txn_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction from a single requester, returning in the idle cycle after the response.
    task automatic lone_txn(input logic is_lsu, input logic [31:0] addr);
        tick();
        if (is_lsu) begin
            lsu_reqValid = 1'b1;
            lsu_addr     = addr;
        end else begin
            ifu_reqValid = 1'b1;
            ifu_addr     = addr;
        end
        tick();
        lsu_reqValid = 1'b0;
        ifu_reqValid = 1'b0;
        tick();
        mem_respValid = 1'b1;
        tick();
        mem_respValid = 1'b0;
    endtask

    initial begin
`ifdef ARB_RR_EN
        exp_first[0] = 1'b1;
        exp_first[1] = 1'b0;
        exp_first[2] = 1'b1;
`else
        exp_first[0] = 1'b1;
        exp_first[1] = 1'b1;
        exp_first[2] = 1'b1;
`endif
        reset         = 1'b1;
        ifu_reqValid  = 1'b0;
        ifu_addr      = 32'h0;
        lsu_reqValid  = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'h0;
        lsu_size      = 2'b00;
        lsu_wen       = 1'b0;
        lsu_wmask     = 4'b0000;
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_mem_reqValid", mem_reqValid, 0);
        check("rst_mem_fields", {mem_wdata ^ mem_addr, 32'(mem_size), 32'(mem_wen), 32'(mem_wmask)} == 128'h0, 1);
        check("rst_grant_lsu", grant_lsu, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_respValid", {ifu_respValid, lsu_respValid}, 0);

        // Lone LSU write
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h0F00_0004;
        lsu_wdata    = 32'hDEAD_BEEF;
        lsu_wmask    = 4'b1100;
        lsu_wen      = 1'b1;
        lsu_size     = 2'b10;
        tick();
        lsu_reqValid = 1'b0;
        lsu_addr     = 32'h0;
        lsu_wdata    = 32'h0;
        lsu_wmask    = 4'b0000;
        lsu_wen      = 1'b0;
        lsu_size     = 2'b00;
        @(negedge clock);
        check("wr_mem_reqValid", mem_reqValid, 1);
        check("wr_mem_addr", mem_addr, 32'h0F00_0004);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_mem_wmask", mem_wmask, 4'b1100);
        check("wr_mem_wen", mem_wen, 1);
        check("wr_mem_size", mem_size, 2'b10);
        check("wr_grant_lsu", grant_lsu, 1);
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0;
        @(negedge clock);
        check("wr_lsu_respValid", lsu_respValid, 1);
        check("wr_ifu_respValid", ifu_respValid, 0);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("wr_lsu_resp_once", lsu_respValid, 0);
        check("wr_idle", busy, 0);
        check("wr_addr_held", mem_addr, 32'h0F00_0004);

        // Lone IFU fetch, response three cycles after the pulse
        tick();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0000;
        tick();
        ifu_reqValid = 1'b0;
        @(negedge clock);
        check("if_mem_reqValid", mem_reqValid, 1);
        check("if_mem_addr", mem_addr, 32'h8000_0000);
        check("if_mem_wen", mem_wen, 0);
        check("if_mem_size", mem_size, 2'b10);
        check("if_grant_lsu", grant_lsu, 0);
        tick();
        @(negedge clock);
        check("if_req_one_cycle", mem_reqValid, 0);
        check("if_busy_wait", busy, 1);
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0013;
        @(negedge clock);
        check("if_ifu_respValid", ifu_respValid, 1);
        check("if_ifu_rdata", ifu_rdata, 32'h0000_0013);
        check("if_lsu_respValid", lsu_respValid, 0);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("if_resp_once", ifu_respValid, 0);
        check("if_idle", busy, 0);

        // Simultaneous pulses: LSU first, IFU replayed from its buffer; early response ignored
        tick();
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0100;
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h1000_0000;
        tick();
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b0;
        ifu_addr      = 32'hFFFF_FFFC;
        mem_respValid = 1'b1;
        mem_rdata     = 32'h1111_1111;
        @(negedge clock);
        check("sim_first_req", mem_reqValid, 1);
        check("sim_first_lsu", grant_lsu, 1);
        check("sim_first_addr", mem_addr, 32'h1000_0000);
        check("sim_early_resp_ignored", {ifu_respValid, lsu_respValid}, 0);
        tick();
        mem_rdata = 32'hAAAA_5555;
        @(negedge clock);
        check("sim_lsu_respValid", lsu_respValid, 1);
        check("sim_lsu_rdata", lsu_rdata, 32'hAAAA_5555);
        check("sim_ifu_quiet", ifu_respValid, 0);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("sim_second_req", mem_reqValid, 1);
        check("sim_second_ifu", grant_lsu, 0);
        check("sim_second_addr", mem_addr, 32'h8000_0100);
        check("sim_second_size", mem_size, 2'b10);
        check("sim_second_wmask", mem_wmask, 4'b0000);
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0093;
        @(negedge clock);
        check("sim_ifu_respValid", ifu_respValid, 1);
        check("sim_lsu_quiet", lsu_respValid, 0);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("sim_idle", busy, 0);

        // Three tie rounds; the lone transactions before rounds 1 and 2 steer the round-robin pointer
        for (int r = 0; r < 3; r++) begin
            if (r == 1) lone_txn(1'b1, 32'h2000_0040);
            if (r == 2) lone_txn(1'b0, 32'h8000_0040);
            tick();
            ifu_reqValid = 1'b1;
            ifu_addr     = 32'h8000_0200 + 32'(r * 4);
            lsu_reqValid = 1'b1;
            lsu_addr     = 32'h2000_0200 + 32'(r * 4);
            tick();
            ifu_reqValid = 1'b0;
            lsu_reqValid = 1'b0;
            @(negedge clock);
            check($sformatf("rr%0d_first", r), grant_lsu, exp_first[r]);
            tick();
            mem_respValid = 1'b1;
            tick();
            mem_respValid = 1'b0;
            @(negedge clock);
            check($sformatf("rr%0d_second", r), {mem_reqValid, grant_lsu}, {1'b1, !exp_first[r]});
            tick();
            mem_respValid = 1'b1;
            tick();
            mem_respValid = 1'b0;
        end

        // IFU pulses again while its first request is still buffered
        ifu_txn_base = ifu_txn_cnt;
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h2000_0000;
        tick();
        lsu_reqValid = 1'b0;
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_1000;
        @(negedge clock);
        check("pe_legal_buffer", proto_err, 0);
        tick();
        ifu_addr = 32'h8000_2000;
        tick();
        ifu_reqValid  = 1'b0;
        mem_respValid = 1'b1;
        @(negedge clock);
        check("pe_proto_err", proto_err, 1);
        check("pe_lsu_respValid", lsu_respValid, 1);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("pe_ifu_req", {mem_reqValid, grant_lsu}, 2'b10);
        check("pe_ifu_addr", mem_addr, 32'h8000_1000);
        tick();
        mem_respValid = 1'b1;
        @(negedge clock);
        check("pe_ifu_respValid", ifu_respValid, 1);
        tick();
        mem_respValid = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check("pe_no_second_req", mem_reqValid, 0);
        check("pe_ifu_txn_count", ifu_txn_cnt - ifu_txn_base, 1);
        check("pe_sticky", proto_err, 1);

        // Reset in ARB_WAIT with an IFU request buffered, then a late response
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h3000_0000;
        tick();
        lsu_reqValid = 1'b0;
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_3000;
        tick();
        ifu_reqValid = 1'b0;
        reset        = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_mem_reqValid", mem_reqValid, 0);
        check("mr_mem_addr", mem_addr, 0);
        check("mr_proto_err", proto_err, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0BAD;
        @(negedge clock);
        check("mr_late_resp_ignored", {ifu_respValid, lsu_respValid}, 0);
        check("mr_idle", busy, 0);
        tick();
        mem_respValid = 1'b0;
        @(negedge clock);
        check("mr_buffer_dropped", mem_reqValid, 0);
        tick();
        @(negedge clock);
        check("mr_still_idle", {mem_reqValid, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter between the instruction fetch unit (IFU) and the load/store unit (LSU) for the single shared memory port. Both requesters use the core's pulse-request/response bus protocol. The arbiter buffers one request per requester, serialises them onto the memory port one transaction at a time, and routes each response back to its owner. It sits between the core's IFU/LSU `io_*` ports and the SoC memory/crossbar.

## Interface
- No parameters; the bus is fixed at 32-bit address and data, 2-bit size and 4-bit wmask.

Ports:
- `clock` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `ifu_reqValid` in 1: one-cycle request pulse (read, word)
- `ifu_addr` in 32: fetch address
- `ifu_respValid` out 1: fetch response
- `ifu_rdata` out 32: fetch data
- `lsu_reqValid` in 1: one-cycle request pulse
- `lsu_addr` in 32: address
- `lsu_wdata` in 32: write data
- `lsu_size` in 2: transfer size
- `lsu_wen` in 1: write enable
- `lsu_wmask` in 4: byte write mask
- `lsu_respValid` out 1: LSU response
- `lsu_rdata` out 32: LSU read data
- `mem_reqValid` out 1: downstream request pulse, registered
- `mem_addr` out 32, `mem_wdata` out 32, `mem_size` out 2, `mem_wen` out 1, `mem_wmask` out 4: registered request fields, held until the next grant
- `mem_respValid` in 1: downstream response
- `mem_rdata` in 32: downstream read data
- `busy` out 1: high in ARB_REQ and ARB_WAIT
- `grant_lsu` out 1: current owner is the LSU (0 = IFU); valid while `busy`
- `proto_err` out 1: sticky protocol-violation flag

## Operation
- Per-requester buffer: a `pend` flag plus captured fields. A pulse sets `pend` and captures the fields, unless that pulse is granted in the same cycle.
- Effective request per requester: `pend | reqValid`. Its fields come from the buffer when `pend` is set, otherwise from the live inputs.
- IFU transactions drive: size 2'b10, wen 0, wmask 4'b0000, wdata 0.
- State machine:
  - **ARB_IDLE**:
    - If any effective request exists, pick a winner and load the `mem_*` field registers from it.
    - Clear the winner's `pend` (or do not set it), record the owner, and go to ARB_REQ.
  - **ARB_REQ**:
    - `mem_reqValid` = 1 for exactly this cycle; go to ARB_WAIT.
    - A `mem_respValid` in this cycle is ignored; its earliest legal cycle is ARB_WAIT.
  - **ARB_WAIT**:
    - On `mem_respValid`, pulse the owner's `respValid` combinationally in the same cycle, with `*_rdata` = `mem_rdata`.
    - In that same cycle, if the other requester's effective request exists, arbitrate and go to ARB_REQ. Otherwise go to ARB_IDLE.
- Tie-break: the LSU wins. Under `ARB_RR_EN` the rule is different (see Configuration).
- `ifu_rdata` and `lsu_rdata` always pass `mem_rdata` through. Only the `respValid` outputs are gated by the owner.
- Protocol violation:
  - A pulse from a requester whose `pend` is already set, or whose transaction is in flight, is dropped.
  - It sets `proto_err` (cleared only by reset).
- An LSU misaligned access is two independent transactions; an IFU grant may be interleaved between them.

## Timing
- Reset values: state ARB_IDLE; `pend` = 0 on both ports; all `mem_*` outputs = 0; `busy` = 0; `grant_lsu` = 0; `proto_err` = 0; both `respValid` = 0; `last_grant` = IFU.
- Latency with the arbiter idle: a pulse at cycle t gives `mem_reqValid` at t+1, the response at t+2 at the earliest, and the requester's `respValid` in the same cycle as `mem_respValid`.
- Back-to-back: an owner's response at cycle t with the other requester pending gives the next `mem_reqValid` at t+1.
- Simultaneous pulses in ARB_IDLE:
  - The winner is issued at t+1.
  - The loser is buffered; it is issued the cycle after the winner's response.
- `mem_respValid` in ARB_IDLE or ARB_REQ is ignored and produces no `respValid`.
- Reset mid-transaction returns to ARB_IDLE and drops buffered requests. A late memory response after reset is ignored.

## Configuration
- `ARB_RR_EN` defined: round-robin tie-break.
  - On simultaneous effective requests, grant the requester not in `last_grant`.
  - `last_grant` updates on every grant.
- `ARB_RR_EN` undefined: fixed priority, the LSU always wins ties; `last_grant` is absent.

## Test plan
- Lone IFU pulse, `ifu_addr`=0x8000_0000, memory responds after 3 cycles with 0x0000_0013 -> `mem_reqValid` at t+1 with wen 0, size 2'b10; `ifu_respValid`=1 and `ifu_rdata`=0x13 in the response cycle; `lsu_respValid` stays 0.
- Lone LSU write, addr 0x0F00_0004, wdata 0xDEAD_BEEF, wmask 4'b1100 -> `mem_*` fields match exactly; `lsu_respValid` pulses once.
- Simultaneous IFU and LSU pulses (no RR) -> LSU issued first; the IFU `mem_reqValid` comes the cycle after the LSU response, with the buffered IFU address intact.
- `ARB_RR_EN`, three rounds of simultaneous pulses -> grant order LSU, IFU, LSU.
- IFU pulses twice while its first request is pending -> second pulse dropped, `proto_err`=1, and exactly one IFU memory transaction.
- Reset asserted in ARB_WAIT, then `mem_respValid` after release -> no `respValid` output, `busy`=0, `mem_reqValid`=0.
